// File: rtl/ref_win_ctrl_if.sv
// Reference-window bus: row loading into the bank RAMs and search reads toward the PE array.
// master = controller side, slave = RAM/PE/upstream side.
interface ref_win_ctrl_if #(
  parameter int NUM_BANKS = 32,
  parameter int AW        = 7,
  parameter int PRE_ROWS  = 4
);
  localparam int RRW = $clog2(PRE_ROWS + 1);

  logic                 load_valid;
  logic                 load_ready;
  logic                 step;
  logic [NUM_BANKS-1:0] bank_sel;
  logic [AW-1:0]        wr_addr;
  logic                 rd_en;
  logic [AW-1:0]        rd_addr;
  logic [RRW-1:0]       rd_rows;

  modport master (
    input  load_valid, step,
    output load_ready, bank_sel, wr_addr, rd_en, rd_addr, rd_rows
  );

  modport slave (
    output load_valid, step,
    input  load_ready, bank_sel, wr_addr, rd_en, rd_addr, rd_rows
  );
endinterface

// File: rtl/ref_win_ctrl.sv
// Reference window controller: loads all bank rows group by group, primes the PE array
// with the first PRE_ROWS rows, then steps through the remaining rows on demand.
//
//   state    | meaning
//   ---------+-----------------------------------------------------------
//   S_IDLE   | waiting for i_start, all outputs low
//   S_LOAD   | accepting row beats, one bank group at a time
//   S_PRIME  | reading rows 0..PRE_ROWS-1 back to back
//   S_SEARCH | reading one further row per step request
//   S_DONE   | single-cycle completion pulse
//
// All outputs are registered and computed from the next state, so they line up with the
// state register. The write for the final load beat lands in the first PRIME cycle.
module ref_win_ctrl #(
  parameter int NUM_BANKS = 32,
  parameter int GROUP     = 4,
  parameter int DEPTH     = 96,
  parameter int AW        = 7,
  parameter int PRE_ROWS  = 4
) (
  input  logic           clk,
  input  logic           rst_n,
  input  logic           i_start,
  input  logic           i_abort,
  output logic           o_busy,
  output logic           o_done,
  ref_win_ctrl_if.master bus
);
  localparam int NGRP = NUM_BANKS / GROUP;
  localparam int GW   = (NGRP > 1) ? $clog2(NGRP) : 1;
  localparam int RRW  = $clog2(PRE_ROWS + 1);
  localparam logic [AW-1:0]        LAST_ROW = AW'(DEPTH - 1);
  localparam logic [AW-1:0]        LAST_PRE = AW'(PRE_ROWS - 1);
  localparam logic [GW-1:0]        LAST_GRP = GW'(NGRP - 1);
  localparam logic [NUM_BANKS-1:0] GRP_MASK = ~({NUM_BANKS{1'b1}} << GROUP);

  typedef enum logic [2:0] {S_IDLE, S_LOAD, S_PRIME, S_SEARCH, S_DONE} state_t;

  state_t               r_state, w_state_nxt;
  logic [GW-1:0]        r_grp;
  logic [AW-1:0]        r_row;
  logic [NUM_BANKS-1:0] r_bank_sel, w_bank_sel;
  logic [AW-1:0]        r_wr_addr, w_wr_addr;
  logic                 r_rd_en, w_rd_en;
  logic [AW-1:0]        r_rd_addr, w_rd_addr;
  logic [RRW-1:0]       r_rd_rows, w_rd_rows;
  logic                 r_load_ready, w_load_ready;
  logic                 r_busy, w_busy;
  logic                 r_done, w_done;
  logic                 w_accept;
  logic                 w_last_beat;

  // abort wins over an otherwise valid beat so nothing is written on the cancel cycle
  assign w_accept    = r_load_ready & bus.load_valid & ~i_abort;
  assign w_last_beat = w_accept && (r_grp == LAST_GRP) && (r_row == LAST_ROW);

  // state register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_state <= S_IDLE;
    else        r_state <= w_state_nxt;
  end

  // next-state decode; abort overrides every transition
  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      S_IDLE:   if (i_start) w_state_nxt = S_LOAD;
      S_LOAD:   if (w_last_beat) w_state_nxt = S_PRIME;
      S_PRIME:  if (r_rd_addr == LAST_PRE) w_state_nxt = (PRE_ROWS == DEPTH) ? S_DONE : S_SEARCH;
      S_SEARCH: if (r_rd_en && (r_rd_addr == LAST_ROW)) w_state_nxt = S_DONE;
      S_DONE:   w_state_nxt = S_IDLE;
      default:  w_state_nxt = S_IDLE;
    endcase
    if (i_abort) w_state_nxt = S_IDLE;
  end

  // next output values, derived from the state being entered
  always_comb begin
    w_bank_sel   = '0;
    w_wr_addr    = r_wr_addr;
    w_rd_en      = 1'b0;
    w_rd_addr    = r_rd_addr;
    w_rd_rows    = '0;
    w_load_ready = (w_state_nxt == S_LOAD);
    w_busy       = (w_state_nxt != S_IDLE);
    w_done       = (w_state_nxt == S_DONE);
    if (w_accept) begin
      w_bank_sel = GRP_MASK << (GROUP * int'(r_grp));
      w_wr_addr  = r_row;
    end
    case (w_state_nxt)
      S_IDLE: begin
        w_wr_addr = '0;
        w_rd_addr = '0;
      end
      S_PRIME: begin
        w_rd_en   = 1'b1;
        w_rd_rows = RRW'(PRE_ROWS);
        w_rd_addr = (r_state == S_PRIME) ? r_rd_addr + 1'b1 : '0;
      end
      S_SEARCH: begin
        w_rd_rows = RRW'(1);
        if ((r_state == S_SEARCH) && bus.step) begin
          w_rd_en   = 1'b1;
          w_rd_addr = r_rd_addr + 1'b1;
        end
      end
      default: ;
    endcase
  end

  // output registers and the group/row load counters
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_grp        <= '0;
      r_row        <= '0;
      r_bank_sel   <= '0;
      r_wr_addr    <= '0;
      r_rd_en      <= 1'b0;
      r_rd_addr    <= '0;
      r_rd_rows    <= '0;
      r_load_ready <= 1'b0;
      r_busy       <= 1'b0;
      r_done       <= 1'b0;
    end else begin
      r_bank_sel   <= w_bank_sel;
      r_wr_addr    <= w_wr_addr;
      r_rd_en      <= w_rd_en;
      r_rd_addr    <= w_rd_addr;
      r_rd_rows    <= w_rd_rows;
      r_load_ready <= w_load_ready;
      r_busy       <= w_busy;
      r_done       <= w_done;
      if (w_state_nxt == S_IDLE) begin
        r_grp <= '0;
        r_row <= '0;
      end else if (w_accept) begin
        if (r_row == LAST_ROW) begin
          r_row <= '0;
          r_grp <= (r_grp == LAST_GRP) ? '0 : r_grp + 1'b1;
        end else begin
          r_row <= r_row + 1'b1;
        end
      end
    end
  end

  assign bus.load_ready = r_load_ready;
  assign bus.bank_sel   = r_bank_sel;
  assign bus.wr_addr    = r_wr_addr;
  assign bus.rd_en      = r_rd_en;
  assign bus.rd_addr    = r_rd_addr;
  assign bus.rd_rows    = r_rd_rows;
  assign o_busy         = r_busy;
  assign o_done         = r_done;
endmodule

// File: doc/ref_win_ctrl.md
REF_WIN_CTRL -- requirements
Module: ref_win_ctrl

Interface
REQ-001 Parameter NUM_BANKS, default 32, number of reference RAM banks.
REQ-002 Parameter GROUP, default 4, banks written together per load phase; NUM_BANKS SHALL be a multiple of GROUP.
REQ-003 Parameter DEPTH, default 96, rows per bank.
REQ-004 Parameter AW, default 7, address width; 2^AW >= DEPTH.
REQ-005 Parameter PRE_ROWS, default 4, rows primed before search; 1 <= PRE_ROWS <= DEPTH.
REQ-006 clk  in  1  clock; all logic on rising edge.
REQ-007 rst_n  in  1  reset, asynchronous, active-low.
REQ-008 start  in  1  begin load; sampled only in IDLE.
REQ-009 abort  in  1  synchronous cancel, any state.
REQ-010 load_valid  in  1  upstream row data valid.
REQ-011 load_ready  out  1  controller accepts a row this cycle.
REQ-012 step  in  1  PE array requests next search row.
REQ-013 bank_sel  out  NUM_BANKS  one-hot-group write enable mask.
REQ-014 wr_addr  out  AW  row address for write, shared by all banks.
REQ-015 rd_en  out  1  read strobe, active-high.
REQ-016 rd_addr  out  AW  row address for read.
REQ-017 rd_rows  out  $clog2(PRE_ROWS+1)  rows PE consumes this read; PRE_ROWS in PRIME, 1 in SEARCH, 0 otherwise.
REQ-018 busy  out  1  high in any state except IDLE.
REQ-019 done  out  1  one-cycle pulse on search completion.

Function
REQ-020 States SHALL be IDLE, LOAD, PRIME, SEARCH, DONE; all outputs registered.
REQ-021 IDLE->LOAD when start=1; start in any other state SHALL be ignored.
REQ-022 In LOAD, load_ready=1; a beat is accepted when load_valid&&load_ready.
REQ-023 On an accepted beat with group index g and row r: next cycle bank_sel has bits [g*GROUP +: GROUP] set, others 0, wr_addr=r; without an accepted beat bank_sel=0.
REQ-024 r counts 0..DEPTH-1 then wraps to 0 and g increments; after beat (g=NUM_BANKS/GROUP-1, r=DEPTH-1) state SHALL go to PRIME and load_ready drops.
REQ-025 Total accepted beats per load SHALL be exactly NUM_BANKS/GROUP*DEPTH (768 at defaults); load_valid gaps only stretch LOAD.
REQ-026 PRIME lasts PRE_ROWS cycles: rd_en=1, rd_addr=0..PRE_ROWS-1 in order, rd_rows=PRE_ROWS, bank_sel=0; then SEARCH.
REQ-027 SEARCH: first rd_addr issued SHALL be PRE_ROWS; each cycle with step=1 issues rd_en=1 at next address; step=0 gives rd_en=0, address held.
REQ-028 After read of address DEPTH-1 state SHALL go to DONE; step ignored in DONE.
REQ-029 DONE lasts one cycle with done=1, then IDLE; start in DONE ignored.
REQ-030 abort=1 SHALL force IDLE next cycle, clear counters, bank_sel=0, rd_en=0, done=0; abort outranks start and step.
REQ-031 In IDLE all outputs SHALL be 0 except none; busy=0.

Reset
REQ-032 On rst_n=0: state IDLE, counters 0, bank_sel=0, wr_addr=0, rd_en=0, rd_addr=0, rd_rows=0, load_ready=0, busy=0, done=0, immediately and asynchronously.
REQ-033 Reset deassertion mid-operation SHALL resume from IDLE only; no partial load retained.

Verification
REQ-034 Defaults, start pulse, load_valid=1 constant -> 768 beats; bank_sel=0x0000000F for beats 0-95, 0xF0000000 for 672-767; wr_addr wraps 95->0.
REQ-035 After load -> 4 PRIME cycles rd_addr 0,1,2,3, rd_rows=4; then step=1 constant -> rd_addr 4..95, done pulse one cycle after address 95, busy falls.
REQ-036 load_valid toggling 1,0 -> bank_sel=0 on idle cycles, still exactly 768 writes, no address skipped.
REQ-037 abort at beat 300 -> next cycle IDLE, bank_sel=0, busy=0; new start restarts at g=0,r=0.
REQ-038 start asserted during LOAD and SEARCH -> no effect on counters or state.
REQ-039 NUM_BANKS=8, GROUP=2, DEPTH=4, PRE_ROWS=2 -> 16 beats, masks 0x03,0x0C,0x30,0xC0; PRIME reads 0,1; SEARCH reads 2,3; done.
